// File: rtl/ddr3_app_responder_if.sv
// DDR3 controller user (app_*) interface bundle: master = controller user, slave = responder.
interface ddr3_app_responder_if #(
  parameter int ADDR_WIDTH     = 27,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr3_app_responder.sv
// In-order DDR3 app-interface responder backed by a small on-chip memory.
// Optional random ready stalls: define DDR3_APP_RESP_STALL_EN.
module ddr3_app_responder #(
  parameter int ADDR_WIDTH     = 27,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
  parameter int MEM_AW         = 6,
  parameter int RD_LATENCY     = 4,
  parameter int FIFO_AW        = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  ddr3_app_responder_if.slave  app
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int MEM_DEPTH  = 1 << MEM_AW;
  localparam int CMD_W      = 3 + MEM_AW;
  localparam int WDF_W      = APP_DATA_WIDTH + APP_MASK_WIDTH;

  logic [CMD_W-1:0]          cmd_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        cmd_wptr_q, cmd_rptr_q;
  logic [FIFO_AW:0]          cmd_cnt_q, cmd_cnt_d;
  logic [WDF_W-1:0]          wdf_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        wdf_wptr_q, wdf_rptr_q;
  logic [FIFO_AW:0]          wdf_cnt_q, wdf_cnt_d;
  logic [APP_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [APP_DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]     pipe_vld_q;
  logic [APP_DATA_WIDTH-1:0] rd_data_q;
  logic                      rd_vld_q;

  logic                      cmd_stall, wdf_stall;
  logic                      cmd_rdy, wdf_rdy;
  logic                      cmd_push, wdf_push;
  logic                      cmd_pop, wdf_pop, rd_issue;
  logic                      cmd_vld, wdf_vld, head_is_wr, head_is_rd;
  logic [CMD_W-1:0]          cmd_head;
  logic [2:0]                head_op;
  logic [MEM_AW-1:0]         head_idx;
  logic [WDF_W-1:0]          wdf_head;
  logic [APP_DATA_WIDTH-1:0] wdf_head_data;
  logic [APP_MASK_WIDTH-1:0] wdf_head_mask;
  logic                      unused_ok;

`ifdef DDR3_APP_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16/14/13/11, shifting right.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lfsr_q <= 16'hACE1;
    else            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign cmd_stall = lfsr_q[0];
  assign wdf_stall = lfsr_q[1];
`else
  assign cmd_stall = 1'b0;
  assign wdf_stall = 1'b0;
`endif

  // Ready comes only from registered counts, never from the request inputs.
  assign cmd_rdy  = !cmd_cnt_q[FIFO_AW] && !cmd_stall;
  assign wdf_rdy  = !wdf_cnt_q[FIFO_AW] && !wdf_stall;
  assign cmd_push = app.app_en && cmd_rdy;
  assign wdf_push = app.app_wdf_wren && wdf_rdy;

  assign cmd_head      = cmd_mem_q[cmd_rptr_q];
  assign head_op       = cmd_head[CMD_W-1 -: 3];
  assign head_idx      = cmd_head[MEM_AW-1:0];
  assign wdf_head      = wdf_mem_q[wdf_rptr_q];
  assign wdf_head_data = wdf_head[WDF_W-1 -: APP_DATA_WIDTH];
  assign wdf_head_mask = wdf_head[APP_MASK_WIDTH-1:0];

  assign cmd_vld    = cmd_cnt_q != '0;
  assign wdf_vld    = wdf_cnt_q != '0;
  assign head_is_wr = head_op == 3'b000;
  assign head_is_rd = head_op == 3'b001;
  // A write at the head waits for its data; everything else retires at once.
  assign cmd_pop    = cmd_vld && (!head_is_wr || wdf_vld);
  assign wdf_pop    = cmd_vld && head_is_wr && wdf_vld;
  assign rd_issue   = cmd_vld && head_is_rd;

  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + 1'b1;
    else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - 1'b1;
  end

  always_comb begin
    wdf_cnt_d = wdf_cnt_q;
    if (wdf_push && !wdf_pop)      wdf_cnt_d = wdf_cnt_q + 1'b1;
    else if (!wdf_push && wdf_pop) wdf_cnt_d = wdf_cnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      wdf_wptr_q <= '0;
      wdf_rptr_q <= '0;
      wdf_cnt_q  <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
      if (wdf_push) wdf_wptr_q <= wdf_wptr_q + 1'b1;
      if (wdf_pop)  wdf_rptr_q <= wdf_rptr_q + 1'b1;
      cmd_cnt_q <= cmd_cnt_d;
      wdf_cnt_q <= wdf_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q] <= {app.app_cmd, app.app_addr[MEM_AW+2:3]};
    if (wdf_push) wdf_mem_q[wdf_wptr_q] <= {app.app_wdf_data, app.app_wdf_mask};
  end

  // Backing store is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge sys_clk) begin
    if (wdf_pop) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!wdf_head_mask[b]) mem_q[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_vld_q  <= '0;
      pipe_data_q <= '{default: '0};
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      pipe_vld_q[0] <= rd_issue;
      if (rd_issue) pipe_data_q[0] <= mem_q[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      rd_vld_q <= pipe_vld_q[RD_LATENCY-1];
      if (pipe_vld_q[RD_LATENCY-1]) rd_data_q <= pipe_data_q[RD_LATENCY-1];
    end
  end

  assign app.app_rdy           = cmd_rdy;
  assign app.app_wdf_rdy       = wdf_rdy;
  assign app.app_rd_data       = rd_data_q;
  assign app.app_rd_data_valid = rd_vld_q;
  assign app.app_rd_data_end   = rd_vld_q;

  // Aliased address bits and the single-beat end flag carry no information here.
  assign unused_ok = ^{app.app_wdf_end, app.app_addr[ADDR_WIDTH-1:MEM_AW+3], app.app_addr[2:0]};

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: latency, masking, backpressure, ordering, reset.
module tb_ddr3_app_responder;
  localparam int AW = 27;
  localparam int DW = 256;
  localparam int MW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_app_responder_if #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) app_if();

  ddr3_app_responder #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
    .MEM_AW(6), .RD_LATENCY(4), .FIFO_AW(2)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .app       (app_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [DW-1:0] rq_data [$];
  int            rq_cyc  [$];
  logic          rq_end  [$];

  localparam logic [DW-1:0] D10 = {64'haaaaaaaaaaaaaaaa, 64'hbbbbbbbbbbbbbbbb,
                                   64'hcccccccccccccccc, 64'hdddddddddddddddd};
  localparam logic [DW-1:0] D20 = {{128{1'b1}}, 128'h0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (app_if.app_rd_data_valid) begin
      rq_data.push_back(app_if.app_rd_data);
      rq_cyc.push_back(cyc);
      rq_end.push_back(app_if.app_rd_data_end);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] wword(input int i);
    wword = {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic clear_q();
    rq_data.delete();
    rq_cyc.delete();
    rq_end.delete();
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int n = 0;
    @(negedge clk);
    app_if.app_en   = 1'b1;
    app_if.app_cmd  = c;
    app_if.app_addr = a;
    while (!app_if.app_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL cmd_accept_timeout: waited %0d cycles, limit 100", n);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    app_if.app_en = 1'b0;
  endtask

  task automatic send_wd(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    @(negedge clk);
    app_if.app_wdf_wren = 1'b1;
    app_if.app_wdf_data = d;
    app_if.app_wdf_mask = m;
    while (!app_if.app_wdf_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wdf_accept_timeout: waited %0d cycles, limit 100", n);
    end
    @(posedge clk);
    #1;
    app_if.app_wdf_wren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (app_if.app_rdy !== 1'b1 || app_if.app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got rdy=%b wdf_rdy=%b want 1 1", app_if.app_rdy, app_if.app_wdf_rdy);
    end
    checks++;
    if (app_if.app_rd_data !== '0 || app_if.app_rd_data_valid !== 1'b0 || app_if.app_rd_data_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd: got valid=%b end=%b data=%h want 0 0 0",
               app_if.app_rd_data_valid, app_if.app_rd_data_end, app_if.app_rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (app_if.app_rdy !== 1'b1 || app_if.app_wdf_rdy !== 1'b1 || app_if.app_rd_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d: got rdy=%b wdf_rdy=%b valid=%b want 1 1 0", i,
                 app_if.app_rdy, app_if.app_wdf_rdy, app_if.app_rd_data_valid);
      end
    end
  endtask

  task automatic test_write_read();
    int racc;
    clear_q();
    send_wd(D10, '0);
    send_cmd(3'b000, 27'h10);
    send_cmd(3'b001, 27'h10);
    racc = last_acc;
    repeat (10) @(negedge clk);
    checks++;
    if (rq_data.size() != 1) begin
      errors++;
      $display("FAIL wr_rd_count: got %0d pulses want 1", rq_data.size());
    end
    if (rq_data.size() >= 1) begin
      checks++;
      if (rq_data[0] !== D10) begin
        errors++;
        $display("FAIL wr_rd_data: got %h want %h", rq_data[0], D10);
      end
      checks++;
      if (rq_cyc[0] - racc != 5) begin
        errors++;
        $display("FAIL rd_latency: got %0d cycles want 5", rq_cyc[0] - racc);
      end
      checks++;
      if (rq_end[0] !== 1'b1) begin
        errors++;
        $display("FAIL rd_end: got %b want 1", rq_end[0]);
      end
    end
  endtask

  task automatic test_mask();
    clear_q();
    send_wd({DW{1'b1}}, '0);
    send_cmd(3'b000, 27'h20);
    send_wd('0, 32'hFFFF0000);
    send_cmd(3'b000, 27'h20);
    send_cmd(3'b001, 27'h20);
    repeat (10) @(negedge clk);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== D20) begin
      errors++;
      $display("FAIL mask_data: got %0d pulses, first %h want 1 pulse %h",
               rq_data.size(), (rq_data.size() > 0) ? rq_data[0] : '0, D20);
    end
  endtask

  task automatic test_wdf_full();
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send_wd(wword(i), '0);
      @(negedge clk);
      checks++;
      if (app_if.app_wdf_rdy !== ((i < 3) ? 1'b1 : 1'b0) || app_if.app_rdy !== 1'b1) begin
        errors++;
        $display("FAIL wdf_fill_%0d: got wdf_rdy=%b rdy=%b want %b 1", i,
                 app_if.app_wdf_rdy, app_if.app_rdy, (i < 3) ? 1'b1 : 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (app_if.app_wdf_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wdf_hold_full: got wdf_rdy=%b want 0", app_if.app_wdf_rdy);
    end
    for (int i = 0; i < 4; i++) send_cmd(3'b000, 27'h100 + 27'(8 * i));
    @(negedge clk);
    checks++;
    if (app_if.app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wdf_recover: got wdf_rdy=%b want 1", app_if.app_wdf_rdy);
    end
    for (int i = 0; i < 4; i++) send_cmd(3'b001, 27'h100 + 27'(8 * i));
    repeat (10) @(negedge clk);
    checks++;
    if (rq_data.size() != 4) begin
      errors++;
      $display("FAIL wdf_rd_count: got %0d pulses want 4", rq_data.size());
    end
    for (int i = 0; i < 4 && i < rq_data.size(); i++) begin
      checks++;
      if (rq_data[i] !== wword(i)) begin
        errors++;
        $display("FAIL wdf_rd_%0d: got %h want %h", i, rq_data[i], wword(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [6];
    logic [DW-1:0] exps  [6];
    int k = 0;
    int g = 0;
    logic acc;
    addrs = '{27'h10, 27'h20, 27'h100, 27'h108, 27'h110, 27'h118};
    exps  = '{D10, D20, wword(0), wword(1), wword(2), wword(3)};
    clear_q();
    send_cmd(3'b000, 27'h1F8);
    app_if.app_wdf_data = wword(9);
    app_if.app_wdf_mask = '0;
    while (k < 6 && g < 200) begin
      @(negedge clk);
      if (g == 3 || g == 8) begin
        checks++;
        if (k != 3 || app_if.app_rdy !== 1'b0) begin
          errors++;
          $display("FAIL cmd_full_%0d: got accepted=%0d rdy=%b want 3 0", g, k, app_if.app_rdy);
        end
      end
      app_if.app_wdf_wren = (g == 8);
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b001;
      app_if.app_addr = addrs[k];
      acc = app_if.app_rdy;
      @(posedge clk);
      if (acc) k++;
      g++;
    end
    @(negedge clk);
    app_if.app_en = 1'b0;
    app_if.app_wdf_wren = 1'b0;
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL b2b_accept: got %0d accepted want 6", k);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (rq_data.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 6", rq_data.size());
    end
    for (int i = 0; i < 6 && i < rq_data.size(); i++) begin
      checks++;
      if (rq_data[i] !== exps[i] || rq_cyc[i] != rq_cyc[0] + i) begin
        errors++;
        $display("FAIL b2b_%0d: got data %h at +%0d want %h at +%0d", i,
                 rq_data[i], rq_cyc[i] - rq_cyc[0], exps[i], i);
      end
    end
  endtask

  task automatic test_bad_cmd();
    clear_q();
    send_cmd(3'b001, 27'h10);
    send_cmd(3'b010, 27'h20);
    send_cmd(3'b001, 27'h20);
    repeat (12) @(negedge clk);
    checks++;
    if (rq_data.size() != 2) begin
      errors++;
      $display("FAIL bad_cmd_count: got %0d pulses want 2", rq_data.size());
    end
    if (rq_data.size() >= 2) begin
      checks++;
      if (rq_data[0] !== D10 || rq_data[1] !== D20) begin
        errors++;
        $display("FAIL bad_cmd_data: got %h / %h want %h / %h", rq_data[0], rq_data[1], D10, D20);
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    send_cmd(3'b001, 27'h100);
    send_cmd(3'b001, 27'h108);
    send_cmd(3'b001, 27'h110);
    rst_n = 1'b0;
    clear_q();
    @(negedge clk);
    checks++;
    if (app_if.app_rd_data_valid !== 1'b0 || app_if.app_rdy !== 1'b1 || app_if.app_wdf_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got valid=%b rdy=%b wdf_rdy=%b want 0 1 1",
               app_if.app_rd_data_valid, app_if.app_rdy, app_if.app_wdf_rdy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rq_data.size() != 0) begin
      errors++;
      $display("FAIL midreset_lost: got %0d pulses want 0", rq_data.size());
    end
    send_cmd(3'b001, 27'h108);
    repeat (10) @(negedge clk);
    checks++;
    if (rq_data.size() != 1 || rq_data[0] !== wword(1)) begin
      errors++;
      $display("FAIL mem_preserved: got %0d pulses, first %h want 1 pulse %h",
               rq_data.size(), (rq_data.size() > 0) ? rq_data[0] : '0, wword(1));
    end
  endtask

  initial begin
    app_if.app_addr     = '0;
    app_if.app_cmd      = 3'b000;
    app_if.app_en       = 1'b0;
    app_if.app_wdf_data = '0;
    app_if.app_wdf_mask = '0;
    app_if.app_wdf_wren = 1'b0;
    app_if.app_wdf_end  = 1'b1;
    test_reset();
    test_write_read();
    test_mask();
    test_wdf_full();
    test_back_to_back();
    test_bad_cmd();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
